pc_sequencer: RTL
=================

# pc_sequencer

Fetch-side controller that owns the program counter for the 3-stage RISC-V core. It sequences reset/boot, sequential fetch, stalls, branch/jump redirects from execute, trap vectoring and halt/resume. It sits between the hazard/execute logic and the instruction memory address port and replaces ad-hoc next-PC muxing in the core top level. It emits the fetch PC, a fetch-valid qualifier and a one-cycle flush to kill wrong-path instructions.

## Interface
Parameters:
- PC_WIDTH, 32, PC width in bits.
- RESET_PC, 32'h4000_0000, BIOS entry; PC value during reset and boot.
- BOOT_CYCLES, 2, cycles held in BOOT after reset release; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit freeze request; hold PC.
- redirect_valid  in  1  execute-stage branch/JAL/JALR taken.
- redirect_target  in  PC_WIDTH  redirect destination.
- trap_valid  in  1  exception/trap request.
- trap_vector  in  PC_WIDTH  trap destination.
- halt  in  1  enter HALT (level, sampled in RUN).
- resume  in  1  leave HALT.
- pc  out  PC_WIDTH  current fetch address (registered).
- pc_plus4  out  PC_WIDTH  pc + 4, combinational.
- fetch_valid  out  1  current fetch is on the correct path.
- flush  out  1  kill IF/ID wrong-path instructions this cycle.
- misalign_err  out  1  one-cycle pulse: accepted target had bits [1:0] != 0.
- state  out  2  FSM state, for debug.

## Operation
- States: BOOT=0, RUN=1, FLUSH=2, HALT=3.
- Reset (rst=0, any time, including mid-redirect): pc=RESET_PC, state=BOOT, boot counter=0, fetch_valid=0, flush=0, misalign_err=0.
- BOOT: pc held at RESET_PC, fetch_valid=0; all requests ignored; counter increments each cycle; at count BOOT_CYCLES-1 go to RUN.
- RUN: fetch_valid=1. Priority per cycle: trap > redirect > halt > stall > sequential.
  - trap or redirect: pc <= target & ~3, next FLUSH; misalign_err <= |target[1:0].
  - halt: next HALT, pc held.
  - stall: pc held, stay RUN.
  - else pc <= pc + 4.
- FLUSH (exactly one cycle per accepted request): flush=1, fetch_valid=1 (fetch at target is valid; older IF/ID contents are killed). Stall and halt ignored. Trap or redirect present: accepted again, pc <= new target, stay FLUSH. Else pc <= pc + 4, next RUN.
- HALT: fetch_valid=0, pc held. Trap -> pc <= vector, FLUSH. Resume (no trap) -> RUN with the same pc. Redirect and stall ignored.
- Arithmetic: pc + 4 is modulo 2^PC_WIDTH; 32'hFFFF_FFFC wraps to 0.
- Outputs flush and misalign_err are registered, decoded from state/flag, and never asserted in BOOT or HALT.

## Timing
- Redirect sampled at edge N: pc=target, flush=1 during cycle N+1; pc=target+4 in cycle N+2. Penalty is one cycle.
- Stall effect is immediate at the next edge; no additional latency.
- Reset release: first fetch_valid=1 occurs BOOT_CYCLES cycles after the first edge with rst=1.
- pc_plus4 tracks pc combinationally, with zero latency.

## Structure
- Package pc_seq_pkg contains:
  - State encoding constants (BOOT/RUN/FLUSH/HALT).
  - The PC_WIDTH default.
  - The RESET_PC default.
  - The instruction alignment mask.
- One combinational sub-module, pc_next_sel, implements the priority mux (trap/redirect/halt/stall/sequential) and produces next pc plus an accept flag.
- The FSM, boot counter and pc register remain in pc_sequencer.

## Test plan
- Reset/boot: hold rst=0, then release with BOOT_CYCLES=2 -> pc=32'h4000_0000 with fetch_valid=0 for 2 cycles, then 4000_0000, 4000_0004, 4000_0008 with fetch_valid=1.
- Redirect: redirect to 32'h4000_0100 at pc 4000_0008 -> next cycle pc=4000_0100 and flush=1; following cycle pc=4000_0104 and flush=0.
- Priority: trap (vector 32'h4000_0200), redirect and stall in the same cycle -> pc=4000_0200 and FLUSH; a redirect during FLUSH to 4000_0300 -> pc=4000_0300 and flush held one more cycle.
- Halt/resume: halt in RUN -> fetch_valid=0 and pc frozen for 5 cycles; resume -> same pc with fetch_valid=1. A trap during HALT -> vector and flush=1.
- Edges:
  - Redirect to 32'h4000_0102 -> pc=4000_0100 and misalign_err pulses once.
  - pc=FFFF_FFFC sequential -> pc=0.
  - rst=0 asserted during FLUSH -> immediate RESET_PC, BOOT, flush=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encoding and defaults for the fetch PC sequencer
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } pc_state_e;

  localparam int          PC_WIDTH_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h4000_0000;
  // Low PC bits that must be zero for a 32-bit instruction fetch
  localparam logic [1:0]  ALIGN_LOW_MASK = 2'b11;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - priority mux choosing the next fetch PC (trap > redirect > halt > stall > sequential)
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  pc_state_e             state,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [PC_WIDTH-1:0]   pc_plus4,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_target,
  input  logic                  trap_valid,
  input  logic [PC_WIDTH-1:0]   trap_vector,
  output logic [PC_WIDTH-1:0]   next_pc,
  output logic                  accept,
  output logic                  misalign
);

  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] aligned;

  always_comb begin
    target   = trap_valid ? trap_vector : redirect_target;
    aligned  = {target[PC_WIDTH-1:2], target[1:0] & ~ALIGN_LOW_MASK};
    next_pc  = pc;
    accept   = 1'b0;
    case (state)
      RUN: begin
        if (trap_valid || redirect_valid) accept = 1'b1;
        else if (!halt && !stall)         next_pc = pc_plus4;
      end
      FLUSH: begin
        if (trap_valid || redirect_valid) accept = 1'b1;
        else                              next_pc = pc_plus4;
      end
      // Only a trap can pull the core out of HALT toward a new address
      HALT: begin
        if (trap_valid) accept = 1'b1;
      end
      default: ;
    endcase
    if (accept) next_pc = aligned;
    misalign = accept && (|target[1:0]);
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC owner: boot, sequential fetch, stall, redirect/trap flush, halt/resume
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = RESET_PC_DEF,
  parameter int                  BOOT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                trap_valid,
  input  logic [PC_WIDTH-1:0] trap_vector,
  input  logic                halt,
  input  logic                resume,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                fetch_valid,
  output logic                flush,
  output logic                misalign_err,
  output logic [1:0]          state
);

  pc_state_e           state_q, state_d;
  logic [3:0]          boot_cnt;
  logic [PC_WIDTH-1:0] pc_q, next_pc;
  logic                mis_q;
  logic                accept, misalign;

  assign pc_plus4 = pc_q + PC_WIDTH'(4);

  pc_next_sel #(.PC_WIDTH(PC_WIDTH)) u_next_sel (
    .state           (state_q),
    .pc              (pc_q),
    .pc_plus4        (pc_plus4),
    .stall           (stall),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .next_pc         (next_pc),
    .accept          (accept),
    .misalign        (misalign)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:  if (boot_cnt == 4'(BOOT_CYCLES - 1)) state_d = RUN;
      RUN: begin
        if (accept)    state_d = FLUSH;
        else if (halt) state_d = HALT;
      end
      FLUSH: state_d = accept ? FLUSH : RUN;
      HALT: begin
        if (accept)      state_d = FLUSH;
        else if (resume) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BOOT;
      boot_cnt <= 4'd0;
      pc_q     <= RESET_PC;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= next_pc;
      // Flag lives only for the FLUSH cycle that follows the offending accept
      mis_q    <= misalign;
      if (state_q == BOOT) boot_cnt <= boot_cnt + 4'd1;
    end
  end

  assign pc           = pc_q;
  assign fetch_valid  = (state_q == RUN) || (state_q == FLUSH);
  assign flush        = (state_q == FLUSH);
  assign misalign_err = mis_q;
  assign state        = state_q;

endmodule
